rf_write_sequencer: RTL

Write-side front end for the CPU register file. Accepts write-back requests from the execute/memory stages through a valid/ready handshake and buffers them in a small FIFO. It serialises them onto the register file's single write port (write enable, 2-bit write mode, 5-bit address, 32-bit data). A 64-bit wide result (MUL/DIV) is split into two consecutive port writes, and an optional scoreboard reports which registers still have writes pending.

---
 rtl/rf_write_sequencer_pkg.sv | 48 ++++
 rtl/rfws_fifo.sv | 57 +++++
 rtl/rf_write_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rf_write_sequencer_pkg.sv
// Shared definitions for the register-file write sequencer: request kinds, port write modes,
// fixed register indices, the request record and the busy-mask helper.
package rf_write_sequencer_pkg;

  typedef enum logic [1:0] {
    RF_WR_FULL = 2'd0,
    RF_WR_HI16 = 2'd1,
    RF_WR_LO16 = 2'd2,
    RF_WR_WIDE = 2'd3
  } rf_wr_kind_e;

  localparam logic [1:0] RF_MODE_FULL = 2'd0;
  localparam logic [1:0] RF_MODE_HI16 = 2'd1;
  localparam logic [1:0] RF_MODE_LO16 = 2'd2;
  localparam logic [1:0] RF_MODE_R11  = 2'd3;

  localparam int unsigned RF_R10 = 10;
  localparam int unsigned RF_R11 = 11;

  typedef struct packed {
    rf_wr_kind_e kind;
    logic [4:0]  addr;
    logic [63:0] data;
  } rf_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWideLo
  } rfws_state_e;

  // Registers a queued request will eventually write.
  function automatic logic [15:0] rf_busy_mask(rf_req_t req);
    logic [15:0] mask;
    mask = '0;
    unique case (req.kind)
      RF_WR_FULL: if (!req.addr[4]) mask[req.addr[3:0]] = 1'b1;
      RF_WR_HI16, RF_WR_LO16: mask[RF_R10] = 1'b1;
      RF_WR_WIDE: begin
        mask[RF_R10] = 1'b1;
        mask[RF_R11] = 1'b1;
      end
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rfws_fifo.sv
// Synchronous request FIFO; exposes head, occupancy and per-slot valid bits so the
// scoreboard can inspect every queued entry.
module rfws_fifo
  import rf_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  rf_req_t                  push_data,
  input  logic                     pop,
  output rf_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         entry_valid,
  output rf_req_t [DEPTH-1:0]      entries
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  rf_req_t [DEPTH-1:0] mem_q;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [PtrW-1:0]     offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: slots are only observed through entry_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    offset      = '0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PtrW'(i) - rd_ptr_q;
      entry_valid[i] = {1'b0, offset} < count_q;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign entries = mem_q;

endmodule

// File: rtl/rf_write_sequencer.sv
// Serialises buffered write-back requests onto the single register-file write port.
// Optional busy scoreboard enabled by defining RFWS_SCOREBOARD_EN.
module rf_write_sequencer
  import rf_write_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [4:0]  req_addr,
  input  logic [63:0] req_data,
  output logic        rf_we,
  output logic [1:0]  rf_control,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic        err_addr,
  output logic [15:0] busy,
  output logic        idle
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  rfws_state_e          state_q, state_d;
  rf_req_t              push_req, head;
  rf_req_t [DEPTH-1:0]  entries;
  logic [DEPTH-1:0]     entry_valid;
  logic [CntW-1:0]      count, count_left;
  logic                 push, pop;

  assign push_req.kind = rf_wr_kind_e'(req_kind);
  assign push_req.addr = req_addr;
  assign push_req.data = req_data;

  assign req_ready = count < CntW'(DEPTH);
  assign push      = req_valid && req_ready;

  rfws_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_data   (push_req),
    .pop         (pop),
    .head        (head),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_control = RF_MODE_FULL;
    rf_addr    = '0;
    rf_data    = '0;
    err_addr   = 1'b0;
    count_left = '0;
    unique case (state_q)
      // A same-cycle push moves straight to ISSUE so a fresh request writes next cycle.
      StIdle: if (push || count != '0) state_d = StIssue;
      StIssue: begin
        unique case (head.kind)
          RF_WR_FULL: begin
            pop = 1'b1;
            if (head.addr[4]) begin
              err_addr = 1'b1;
            end else begin
              rf_we   = 1'b1;
              rf_addr = head.addr;
              rf_data = head.data[31:0];
            end
          end
          RF_WR_HI16: begin
            pop        = 1'b1;
            rf_we      = 1'b1;
            rf_control = RF_MODE_HI16;
            rf_data    = head.data[31:0];
          end
          RF_WR_LO16: begin
            pop        = 1'b1;
            rf_we      = 1'b1;
            rf_control = RF_MODE_LO16;
            rf_data    = head.data[31:0];
          end
          RF_WR_WIDE: begin
            rf_we      = 1'b1;
            rf_control = RF_MODE_R11;
            rf_addr    = 5'(RF_R11);
            rf_data    = head.data[63:32];
            state_d    = StWideLo;
          end
          default: state_d = StIdle;
        endcase
      end
      StWideLo: begin
        pop        = 1'b1;
        rf_we      = 1'b1;
        rf_control = RF_MODE_FULL;
        rf_addr    = 5'(RF_R10);
        rf_data    = head.data[31:0];
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      count_left = count + CntW'(push) - CntW'(1);
      state_d    = (count_left != '0) ? StIssue : StIdle;
    end
  end

  assign idle = (count == '0) && (state_q == StIdle);

`ifdef RFWS_SCOREBOARD_EN
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy = busy | rf_busy_mask(entries[i]);
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{entry_valid, entries};
  assign busy      = 16'h0000;
`endif

endmodule
